// File: rtl/reaction_stats_pkg.sv
// Shared types and constants for the reaction-timer statistics block.
package reaction_stats_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LATCH  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  localparam logic [1:0] DISP_LAST = 2'd0;
  localparam logic [1:0] DISP_BEST = 2'd1;
  localparam logic [1:0] DISP_AVG  = 2'd2;
  localparam logic [1:0] DISP_CNT  = 2'd3;

  localparam logic [CNT_W-1:0] ATTEMPT_MAX = 16'd9999;

  // Attempt counter increment that holds at the 4-digit display limit.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= ATTEMPT_MAX) ? ATTEMPT_MAX : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/reaction_stats_avg.sv
// Rolling average over the most recent DEPTH valid attempts.
module rolling_avg
  import reaction_stats_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] data_i,
  output logic [CNT_W-1:0] avg_o,
  output logic             avg_valid_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = CNT_W + PTR_W;
  localparam int unsigned NV_W  = PTR_W + 1;

  logic [CNT_W-1:0] hist_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [NV_W-1:0]  n_valid_q, n_valid_d;
  logic [CNT_W-1:0] avg_q, avg_d;
  logic             avg_valid_q, avg_valid_d;

  // Replace the oldest sample in the running sum and advance the write slot.
  always_comb begin
    sum_d     = sum_q;
    wr_ptr_d  = wr_ptr_q;
    n_valid_d = n_valid_q;
    if (wr_en_i) begin
      sum_d     = sum_q - SUM_W'(hist_q[wr_ptr_q]) + SUM_W'(data_i);
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      n_valid_d = (n_valid_q == NV_W'(DEPTH)) ? n_valid_q : n_valid_q + NV_W'(1);
    end
    avg_d       = CNT_W'(sum_d >> PTR_W);
    avg_valid_d = (n_valid_d == NV_W'(DEPTH));
  end

  // History, pointer, sum and averaged result registers.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      for (int i = 0; i < int'(DEPTH); i++) hist_q[i] <= '0;
      wr_ptr_q    <= '0;
      sum_q       <= '0;
      n_valid_q   <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      if (wr_en_i) hist_q[wr_ptr_q] <= data_i;
      wr_ptr_q    <= wr_ptr_d;
      sum_q       <= sum_d;
      n_valid_q   <= n_valid_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign avg_o       = avg_q;
  assign avg_valid_o = avg_valid_q;

endmodule

// File: rtl/reaction_stats.sv
// Reaction-time statistics: classify each finished run, track last/best/average.
module reaction_stats
  import reaction_stats_pkg::*;
#(
  parameter int unsigned      DEPTH     = 4,
  parameter logic [CNT_W-1:0] MIN_VALID = 16'd100,
  parameter logic [CNT_W-1:0] SAT_VALUE = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic [CNT_W-1:0] count_in,
  input  logic             clear,
  input  logic [1:0]       disp_sel,
  output logic [CNT_W-1:0] disp_out,
  output logic             best_valid,
  output logic             avg_valid,
  output logic             new_best,
  output logic             rejected,
  output logic             done,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cap_q, cap_d;
  logic             rej_q, rej_d;
  logic             nb_q, nb_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic             best_valid_q, best_valid_d;
  logic [CNT_W-1:0] att_q, att_d;
  logic             done_q, done_d;
  logic             new_best_q, new_best_d;
  logic             rejected_q, rejected_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] disp_q, disp_d;
  logic             wr_en_c;
  logic [CNT_W-1:0] avg_c;
  logic             avg_valid_c;

  rolling_avg #(.DEPTH(DEPTH)) u_avg (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clear),
    .wr_en_i     (wr_en_c),
    .data_i      (cap_q),
    .avg_o       (avg_c),
    .avg_valid_o (avg_valid_c)
  );

  // Next-state, statistics update and registered pulse/display values.
  always_comb begin
    state_d      = state_q;
    cap_d        = cap_q;
    rej_d        = rej_q;
    nb_d         = nb_q;
    last_d       = last_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    att_d        = att_q;
    wr_en_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // busy_q still covers the done cycle, so a stop there is dropped.
        if (stop && !busy_q) begin
          cap_d   = count_in;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        rej_d   = (cap_q < MIN_VALID) || (cap_q == SAT_VALUE);
        nb_d    = 1'b0;
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        last_d = cap_q;
        att_d  = sat_inc(att_q);
        if (!rej_q) begin
          wr_en_c      = 1'b1;
          best_valid_d = 1'b1;
          if (cap_q < best_q) begin
            best_d = cap_q;
            nb_d   = 1'b1;
          end
        end
        state_d = ST_REPORT;
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    done_d     = (state_q == ST_REPORT);
    new_best_d = (state_q == ST_REPORT) && nb_q;
    rejected_d = (state_q == ST_REPORT) && rej_q;
    busy_d     = (state_d != ST_IDLE) || (state_q == ST_REPORT);

    case (disp_sel)
      DISP_LAST: disp_d = last_q;
      DISP_BEST: disp_d = best_valid_q ? best_q : '0;
      DISP_AVG:  disp_d = avg_valid_c ? avg_c : '0;
      DISP_CNT:  disp_d = att_q;
      default:   disp_d = '0;
    endcase
  end

  // State and output registers; clear acts exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q      <= ST_IDLE;
      cap_q        <= '0;
      rej_q        <= 1'b0;
      nb_q         <= 1'b0;
      last_q       <= '0;
      best_q       <= 16'hFFFF;
      best_valid_q <= 1'b0;
      att_q        <= '0;
      done_q       <= 1'b0;
      new_best_q   <= 1'b0;
      rejected_q   <= 1'b0;
      busy_q       <= 1'b0;
      disp_q       <= '0;
    end else begin
      state_q      <= state_d;
      cap_q        <= cap_d;
      rej_q        <= rej_d;
      nb_q         <= nb_d;
      last_q       <= last_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
      att_q        <= att_d;
      done_q       <= done_d;
      new_best_q   <= new_best_d;
      rejected_q   <= rejected_d;
      busy_q       <= busy_d;
      disp_q       <= disp_d;
    end
  end

  assign disp_out   = disp_q;
  assign best_valid = best_valid_q;
  assign avg_valid  = avg_valid_c;
  assign new_best   = new_best_q;
  assign rejected   = rejected_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_reaction_stats.sv
// Self-checking bench for reaction_stats (DEPTH = 4).
module tb_reaction_stats;

  logic        clk;
  logic        reset;
  logic        stop;
  logic [15:0] count_in;
  logic        clear;
  logic [1:0]  disp_sel;
  logic [15:0] disp_out;
  logic        best_valid;
  logic        avg_valid;
  logic        new_best;
  logic        rejected;
  logic        done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] cnt_in;
    logic        exp_nb;
    logic        exp_rej;
    logic [15:0] exp_last;
    logic [15:0] exp_best;
    logic [15:0] exp_avg;
    logic [15:0] exp_att;
    logic        exp_bv;
    logic        exp_av;
  } vec_t;

  vec_t tbl [11];
  vec_t exp_q [$];

  reaction_stats dut (
    .clk        (clk),
    .reset      (reset),
    .stop       (stop),
    .count_in   (count_in),
    .clear      (clear),
    .disp_sel   (disp_sel),
    .disp_out   (disp_out),
    .best_valid (best_valid),
    .avg_valid  (avg_valid),
    .new_best   (new_best),
    .rejected   (rejected),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic read_disp(input logic [1:0] s, output logic [15:0] v);
    disp_sel = s;
    tick();
    v = disp_out;
  endtask

  task automatic check_stats(input string tag, input int e_last, input int e_best,
                             input int e_avg, input int e_att);
    logic [15:0] v;
    read_disp(2'd0, v); chk({tag, "_last"}, int'(v), e_last);
    read_disp(2'd1, v); chk({tag, "_best"}, int'(v), e_best);
    read_disp(2'd2, v); chk({tag, "_avg"},  int'(v), e_avg);
    read_disp(2'd3, v); chk({tag, "_att"},  int'(v), e_att);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // One full attempt: push expectation, pulse stop, pop and compare at done.
  task automatic run_attempt(input string tag, input vec_t v);
    int lat;
    vec_t e;
    wait_idle();
    exp_q.push_back(v);
    count_in = v.cnt_in;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    lat = 1;
    chk({tag, "_busy_t1"}, int'(busy), 1);
    while (!done && lat < 10) begin tick(); lat++; end
    e = exp_q.pop_front();
    if (!done) begin
      chk({tag, "_done_timeout"}, 0, 1);
    end else begin
      chk({tag, "_latency"}, lat, 4);
      chk({tag, "_busy_done"}, int'(busy), 1);
      chk({tag, "_new_best"}, int'(new_best), int'(e.exp_nb));
      chk({tag, "_rejected"}, int'(rejected), int'(e.exp_rej));
      chk({tag, "_best_valid"}, int'(best_valid), int'(e.exp_bv));
      chk({tag, "_avg_valid"}, int'(avg_valid), int'(e.exp_av));
      tick();
      chk({tag, "_done_pulse"}, int'(done), 0);
      chk({tag, "_busy_after"}, int'(busy), 0);
    end
    check_stats(tag, int'(e.exp_last), int'(e.exp_best), int'(e.exp_avg), int'(e.exp_att));
  endtask

  initial begin
    int ndone;
    int dcyc;
    vec_t v;

    tbl[0]  = '{16'd250,   1'b1, 1'b0, 16'd250,   16'd250, 16'd0,     16'd1,  1'b1, 1'b0};
    tbl[1]  = '{16'd300,   1'b0, 1'b0, 16'd300,   16'd250, 16'd0,     16'd2,  1'b1, 1'b0};
    tbl[2]  = '{16'd200,   1'b1, 1'b0, 16'd200,   16'd200, 16'd0,     16'd3,  1'b1, 1'b0};
    tbl[3]  = '{16'd400,   1'b0, 1'b0, 16'd400,   16'd200, 16'd287,   16'd4,  1'b1, 1'b1};
    tbl[4]  = '{16'd100,   1'b1, 1'b0, 16'd100,   16'd100, 16'd250,   16'd5,  1'b1, 1'b1};
    tbl[5]  = '{16'd500,   1'b0, 1'b0, 16'd500,   16'd100, 16'd300,   16'd6,  1'b1, 1'b1};
    tbl[6]  = '{16'd50,    1'b0, 1'b1, 16'd50,    16'd100, 16'd300,   16'd7,  1'b1, 1'b1};
    tbl[7]  = '{16'hFFFF,  1'b0, 1'b1, 16'hFFFF,  16'd100, 16'd300,   16'd8,  1'b1, 1'b1};
    tbl[8]  = '{16'd99,    1'b0, 1'b1, 16'd99,    16'd100, 16'd300,   16'd9,  1'b1, 1'b1};
    tbl[9]  = '{16'd100,   1'b0, 1'b0, 16'd100,   16'd100, 16'd275,   16'd10, 1'b1, 1'b1};
    tbl[10] = '{16'd65534, 1'b0, 1'b0, 16'd65534, 16'd100, 16'd16558, 16'd11, 1'b1, 1'b1};

    reset = 1'b1; stop = 1'b0; count_in = '0; clear = 1'b0; disp_sel = 2'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_best_valid", int'(best_valid), 0);
    chk("rst_avg_valid", int'(avg_valid), 0);
    chk("rst_new_best", int'(new_best), 0);
    chk("rst_rejected", int'(rejected), 0);
    check_stats("rst", 0, 0, 0, 0);

    for (int i = 0; i < 11; i++) run_attempt($sformatf("vec%0d", i), tbl[i]);

    // Extra stops at t+2 and in the done cycle must both be dropped.
    wait_idle();
    count_in = 16'd70;
    stop = 1'b1;
    ndone = 0;
    dcyc = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      stop = 1'b0;
      if (c == 2) begin stop = 1'b1; count_in = 16'd90; end
      if (done) begin
        ndone++;
        dcyc = c;
        stop = 1'b1;
        count_in = 16'd95;
      end
    end
    stop = 1'b0;
    chk("ign_done_count", ndone, 1);
    chk("ign_done_cycle", dcyc, 4);
    chk("ign_busy", int'(busy), 0);
    check_stats("ign", 70, 100, 16558, 12);

    // Clear during UPDATE aborts the attempt with no done pulse.
    wait_idle();
    count_in = 16'd300;
    stop = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      stop = 1'b0;
      clear = (c == 2);
      if (done) ndone++;
    end
    clear = 1'b0;
    chk("clr_done_count", ndone, 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_best_valid", int'(best_valid), 0);
    chk("clr_avg_valid", int'(avg_valid), 0);
    check_stats("clr", 0, 0, 0, 0);

    v = '{16'd300, 1'b1, 1'b0, 16'd300, 16'd300, 16'd0, 16'd1, 1'b1, 1'b0};
    run_attempt("restart", v);

    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
